lsu_ctrl: RTL and testbench

Load/store control stage sitting directly upstream of the physical-memory model. Accepts one load or store per handshake from the execute stage, aligns write data and byte mask to the 32-bit memory word, and drives the memory request for a fixed number of cycles. It then captures and sign- or zero-extends the returned word and holds the result for the write-back stage until that stage accepts it.

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_align.sv | 48 ++++
 rtl/lsu_ctrl.sv | 154 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store control stage.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int WMASK_W = 8;

    // Half needs an even offset, word needs offset 0; size 3 behaves as a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: offset masking, store data/mask shift,
// and load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]         off_i,
    input  logic [1:0]         size_i,
    input  logic               sext_i,
    input  logic [31:0]        wdata_i,
    input  logic [31:0]        rdata_i,
    output logic [31:0]        wdata_o,
    output logic [WMASK_W-1:0] wmask_o,
    output logic [31:0]        rdata_o
);

    logic [1:0]         off_eff;
    logic [3:0]         base_mask;
    logic [WMASK_W-1:0] base_mask_w;
    logic [31:0]        rshift;

    // Offset is forced to natural alignment so the lanes never straddle the word.
    always_comb begin
        off_eff   = off_i;
        base_mask = 4'b1111;
        case (size_i)
            SZ_B: base_mask = 4'b0001;
            SZ_H: begin
                base_mask = 4'b0011;
                off_eff   = {off_i[1], 1'b0};
            end
            default: off_eff = 2'b00;
        endcase
        base_mask_w = {{(WMASK_W-4){1'b0}}, base_mask};
        wmask_o     = base_mask_w << off_eff;
        wdata_o     = wdata_i << {off_eff, 3'b000};
        rshift      = rdata_i >> {off_eff, 3'b000};
    end

    // Extract the addressed byte/half and extend it; words pass through.
    always_comb begin
        case (size_i)
            SZ_B:    rdata_o = {{24{sext_i & rshift[7]}}, rshift[7:0]};
            SZ_H:    rdata_o = {{16{sext_i & rshift[15]}}, rshift[15:0]};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control stage in front of the memory model.
// Optional macro LSU_MISALIGN_CHECK_EN: misaligned requests bypass memory and
// respond with out_err=1; without it the offset is masked and the access proceeds.
//
// state   | meaning
// IDLE    | in_ready=1, waiting for a request
// REQ     | first memory cycle, mem_wen pulses here for stores
// WAIT    | extra LATENCY cycles of held request, capture at count 1
// RESP    | result held on out_* until out_ready
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int LATENCY = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_addr,
    input  logic               in_wen,
    input  logic [1:0]         in_size,
    input  logic               in_sext,
    input  logic [31:0]        in_wdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_rdata,
`ifdef LSU_MISALIGN_CHECK_EN
    output logic               out_err,
`endif
    output logic               mem_valid,
    output logic [31:0]        mem_raddr,
    input  logic [31:0]        mem_rdata,
    output logic               mem_wen,
    output logic [31:0]        mem_waddr,
    output logic [31:0]        mem_wdata,
    output logic [WMASK_W-1:0] mem_wmask
);

    localparam logic [3:0] LAT_CNT = 4'(LATENCY);

    lsu_state_e         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [31:0]        addr_q, wdata_q, rdata_q;
    logic               wen_q, sext_q;
    logic [1:0]         size_q;
    logic               accept, accept_err, capture, mem_active;
    logic [31:0]        al_wdata, al_rdata;
    logic [WMASK_W-1:0] al_wmask;

    assign accept = in_valid && (state_q == ST_IDLE);

`ifdef LSU_MISALIGN_CHECK_EN
    logic err_q;
    assign accept_err = is_misaligned(in_size, in_addr[1:0]);
    assign out_err    = out_valid & err_q;
`else
    assign accept_err = 1'b0;
`endif

    lsu_align u_align (
        .off_i   (addr_q[1:0]),
        .size_i  (size_q),
        .sext_i  (sext_q),
        .wdata_i (wdata_q),
        .rdata_i (mem_rdata),
        .wdata_o (al_wdata),
        .wmask_o (al_wmask),
        .rdata_o (al_rdata)
    );

    // Next-state logic; capture marks the last memory cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) state_d = accept_err ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                if (LATENCY == 0) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = LAT_CNT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latency counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request registers and the extended result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            size_q  <= SZ_B;
            sext_q  <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            wen_q   <= in_wen;
            size_q  <= in_size;
            sext_q  <= in_sext;
            rdata_q <= '0;
        end else if (capture) begin
            rdata_q <= wen_q ? 32'd0 : al_rdata;
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    // Error flag latched at acceptance and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      err_q <= 1'b0;
        else if (accept) err_q <= accept_err;
    end
`endif

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_RESP);
    assign out_rdata  = out_valid ? rdata_q : 32'd0;
    assign mem_active = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign mem_valid  = mem_active;
    assign mem_wen    = (state_q == ST_REQ) && wen_q;
    assign mem_raddr  = mem_active ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_waddr  = mem_raddr;
    assign mem_wdata  = mem_active ? al_wdata : 32'd0;
    assign mem_wmask  = mem_active ? al_wmask : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench: two instances (LATENCY 0 and 3) share all inputs.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_wen, in_sext, out_ready;
    logic [31:0] in_addr, in_wdata, mem_rdata;
    logic [1:0]  in_size;

    logic        u0_in_ready, u0_out_valid, u0_mem_valid, u0_mem_wen;
    logic [31:0] u0_out_rdata, u0_mem_raddr, u0_mem_waddr, u0_mem_wdata;
    logic [7:0]  u0_mem_wmask;
    logic        u3_in_ready, u3_out_valid, u3_mem_valid, u3_mem_wen;
    logic [31:0] u3_out_rdata, u3_mem_raddr, u3_mem_waddr, u3_mem_wdata;
    logic [7:0]  u3_mem_wmask;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        u0_out_err, u3_out_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.LATENCY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u0_in_ready),
        .in_addr(in_addr), .in_wen(in_wen), .in_size(in_size), .in_sext(in_sext),
        .in_wdata(in_wdata), .out_valid(u0_out_valid), .out_ready(out_ready),
        .out_rdata(u0_out_rdata),
`ifdef LSU_MISALIGN_CHECK_EN
        .out_err(u0_out_err),
`endif
        .mem_valid(u0_mem_valid), .mem_raddr(u0_mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(u0_mem_wen), .mem_waddr(u0_mem_waddr), .mem_wdata(u0_mem_wdata),
        .mem_wmask(u0_mem_wmask)
    );

    lsu_ctrl #(.LATENCY(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u3_in_ready),
        .in_addr(in_addr), .in_wen(in_wen), .in_size(in_size), .in_sext(in_sext),
        .in_wdata(in_wdata), .out_valid(u3_out_valid), .out_ready(out_ready),
        .out_rdata(u3_out_rdata),
`ifdef LSU_MISALIGN_CHECK_EN
        .out_err(u3_out_err),
`endif
        .mem_valid(u3_mem_valid), .mem_raddr(u3_mem_raddr), .mem_rdata(mem_rdata),
        .mem_wen(u3_mem_wen), .mem_waddr(u3_mem_waddr), .mem_wdata(u3_mem_wdata),
        .mem_wmask(u3_mem_wmask)
    );

    localparam logic [31:0] V_ADDR [4] = '{32'h80000000, 32'h80000001, 32'h80000002, 32'h80000004};
    localparam logic [1:0]  V_SIZE [4] = '{2'd1, 2'd0, 2'd0, 2'd3};
    localparam logic        V_SEXT [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic [31:0] V_RD   [4] = '{32'h1234F00D, 32'h1234F0AB, 32'h00417F00, 32'h89ABCDEF};
    localparam logic [31:0] V_EXP  [4] = '{32'hFFFFF00D, 32'h000000F0, 32'h00000041, 32'h89ABCDEF};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request; returns one step after the accepting edge (k=1).
    task automatic send(input logic [31:0] a, input logic w, input logic [1:0] sz,
                        input logic sx, input logic [31:0] wd);
        check("accept_rdy", 32'(u0_in_ready & u3_in_ready), 32'd1);
        in_addr  = a;
        in_wen   = w;
        in_size  = sz;
        in_sext  = sx;
        in_wdata = wd;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        for (n = 0; n < 30; n++) begin
            if (u0_in_ready && u3_in_ready) break;
            step();
        end
        check("drain_idle", 32'(u0_in_ready & u3_in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_a, cnt_b, cnt_c, first, viol;
        logic [31:0] rd;
        in_valid = 0; in_wen = 0; in_sext = 0; out_ready = 0;
        in_addr = 0; in_wdata = 0; in_size = 0; mem_rdata = 0;

        #2;
        check("rst_in_ready", 32'(u0_in_ready), 32'd1);
        check("rst_out_valid", 32'(u0_out_valid), 32'd0);
        check("rst_mem_valid", 32'(u3_mem_valid), 32'd0);
        check("rst_mem_raddr", u3_mem_raddr, 32'd0);
        check("rst_out_rdata", u0_out_rdata, 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Signed byte load at offset 3, LATENCY 0.
        mem_rdata = 32'h80FF1234;
        send(32'h80000003, 1'b0, 2'd0, 1'b1, 32'd0);
        check("t1_mem_valid", 32'(u0_mem_valid), 32'd1);
        check("t1_raddr", u0_mem_raddr, 32'h80000000);
        check("t1_waddr", u0_mem_waddr, 32'h80000000);
        check("t1_wen", 32'(u0_mem_wen), 32'd0);
        check("t1_ov_early", 32'(u0_out_valid), 32'd0);
        step();
        check("t1_out_valid", 32'(u0_out_valid), 32'd1);
        check("t1_rdata", u0_out_rdata, 32'hFFFFFF80);
        check("t1_mem_idle", 32'(u0_mem_valid), 32'd0);
        check("t1_raddr_idle", u0_mem_raddr, 32'd0);
        check("t1_in_ready", 32'(u0_in_ready), 32'd0);
`ifdef LSU_MISALIGN_CHECK_EN
        check("t1_err", 32'(u0_out_err), 32'd0);
`endif
        drain();

        // Store half at offset 2.
        send(32'h80000002, 1'b1, 2'd1, 1'b0, 32'h0000ABCD);
        check("t2_wmask", 32'(u0_mem_wmask), 32'h0000000C);
        check("t2_wdata", u0_mem_wdata, 32'hABCD0000);
        check("t2_wen", 32'(u0_mem_wen), 32'd1);
        check("t2_wmask_l3", 32'(u3_mem_wmask), 32'h0000000C);
        cnt_a = 0; cnt_b = 0; cnt_c = 0; rd = 0;
        for (int k = 1; k <= 8; k++) begin
            if (u3_mem_wen) cnt_a++;
            if (u0_mem_wen) cnt_b++;
            if (u3_mem_valid) cnt_c++;
            if (k == 3) rd = u3_mem_wdata;
            step();
        end
        check("t2_wen_cnt_l3", 32'(cnt_a), 32'd1);
        check("t2_wen_cnt_l0", 32'(cnt_b), 32'd1);
        check("t2_mv_cnt_l3", 32'(cnt_c), 32'd4);
        check("t2_wdata_held", rd, 32'hABCD0000);
        check("t2_rdata_l0", u0_out_rdata, 32'd0);
        check("t2_rdata_l3", u3_out_rdata, 32'd0);
        check("t2_ov_l3", 32'(u3_out_valid), 32'd1);
        drain();

        // Word load; memory data changes on the last memory cycle of LATENCY 3.
        mem_rdata = 32'h11111111;
        send(32'h80000010, 1'b0, 2'd2, 1'b0, 32'd0);
        cnt_a = 0; first = 0; rd = 0;
        for (int k = 1; k <= 8; k++) begin
            if (u3_mem_valid) cnt_a++;
            if (u3_out_valid && first == 0) begin
                first = k;
                rd = u3_out_rdata;
            end
            if (k == 4) mem_rdata = 32'hCAFEF00D;
            step();
        end
        check("t3_mv_cnt", 32'(cnt_a), 32'd4);
        check("t3_ov_cycle", 32'(first), 32'd5);
        check("t3_rdata_l3", rd, 32'hCAFEF00D);
        check("t3_rdata_l0", u0_out_rdata, 32'h11111111);
        drain();

        // Backpressure on an unsigned half load.
        mem_rdata = 32'h87654321;
        send(32'h80000002, 1'b0, 2'd1, 1'b0, 32'd0);
        step();
        viol = 0;
        for (int k = 0; k < 10; k++) begin
            if (!u0_out_valid || u0_out_rdata !== 32'h00008765 || u0_in_ready) viol++;
            step();
        end
        check("t4_hold", 32'(viol), 32'd0);
        check("t4_rdata", u0_out_rdata, 32'h00008765);
        out_ready = 1'b1;
        step();
        check("t4_idle", 32'(u0_in_ready), 32'd1);
        check("t4_ov_low", 32'(u0_out_valid), 32'd0);
        drain();

        // Extension table.
        for (int i = 0; i < 4; i++) begin
            mem_rdata = V_RD[i];
            send(V_ADDR[i], 1'b0, V_SIZE[i], V_SEXT[i], 32'd0);
            step();
            check($sformatf("t5_ext%0d", i), u0_out_rdata, V_EXP[i]);
            drain();
        end

`ifndef LSU_MISALIGN_CHECK_EN
        // Misaligned accesses are masked to natural alignment.
        send(32'h80000003, 1'b1, 2'd1, 1'b0, 32'h0000ABCD);
        check("t6_mask_wmask", 32'(u0_mem_wmask), 32'h0000000C);
        check("t6_mask_wdata", u0_mem_wdata, 32'hABCD0000);
        drain();
        mem_rdata = 32'h89ABCDEF;
        send(32'h80000001, 1'b0, 2'd2, 1'b0, 32'd0);
        check("t6_mask_mv", 32'(u0_mem_valid), 32'd1);
        step();
        check("t6_mask_word", u0_out_rdata, 32'h89ABCDEF);
        drain();
`else
        // Misaligned word load bypasses memory.
        mem_rdata = 32'h89ABCDEF;
        send(32'h80000001, 1'b0, 2'd2, 1'b0, 32'd0);
        check("t6_err", 32'(u0_out_err), 32'd1);
        check("t6_err_l3", 32'(u3_out_err), 32'd1);
        check("t6_ov", 32'(u3_out_valid), 32'd1);
        check("t6_rdata", u0_out_rdata, 32'd0);
        cnt_a = 0;
        for (int k = 0; k < 6; k++) begin
            if (u0_mem_valid || u3_mem_valid) cnt_a++;
            step();
        end
        check("t6_no_mem", 32'(cnt_a), 32'd0);
        drain();
        send(32'h80000003, 1'b0, 2'd1, 1'b0, 32'd0);
        check("t6_err_half", 32'(u3_out_err), 32'd1);
        drain();
`endif

        // Reset in the middle of WAIT.
        out_ready = 1'b1;
        send(32'h80000020, 1'b0, 2'd2, 1'b0, 32'd0);
        step();
        check("t7_pre_mv", 32'(u3_mem_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_mv_drop", 32'(u3_mem_valid), 32'd0);
        check("t7_raddr_drop", u3_mem_raddr, 32'd0);
        check("t7_in_ready", 32'(u3_in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        viol = 0;
        for (int k = 0; k < 8; k++) begin
            if (u3_out_valid || u3_mem_valid) viol++;
            step();
        end
        check("t7_no_resp", 32'(viol), 32'd0);
        check("t7_ready_after", 32'(u3_in_ready), 32'd1);
        out_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
